mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits before fetch is forced priority (range 1..15).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch requests a word read; held with if_addr stable until if_done.
REQ-005 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_flush  input  1  cancel the pending or in-flight fetch.
REQ-007 m_MemRead  input  1  data-stage load request.
REQ-008 m_MemWrite  input  1  data-stage store request; never asserted together with m_MemRead.
REQ-009 m_alu_out  input  32  data byte address; bits [1:0] ignored.
REQ-010 m_mem_data  input  32  store data.
REQ-011 mem_req  output  1  memory transaction valid.
REQ-012 mem_we  output  1  1 = write, 0 = read.
REQ-013 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 mem_wdata  output  32  write data.
REQ-015 mem_ack  input  1  memory completes the current transaction this cycle.
REQ-016 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-017 if_stall / m_stall  output  1 each  hold the requesting stage.
REQ-018 if_done / m_done  output  1 each  one-cycle completion pulse.
REQ-019 if_rdata / m_rdata  output  32 each  registered read data, held until the next completion for that requester.

Function
REQ-020 FSM states: IDLE, FETCH, DATA; the state register is the only source of grant.
REQ-021 IDLE: a data request (m_MemRead|m_MemWrite) SHALL go to DATA, except when the starvation counter equals STARVE_LIMIT and if_req=1 && if_flush=0, which SHALL go to FETCH; a fetch request alone SHALL go to FETCH; no request SHALL stay in IDLE.
REQ-022 mem_addr, mem_we and mem_wdata SHALL be registered on the IDLE->grant edge and held constant while mem_req=1.
REQ-023 mem_req SHALL be 1 in FETCH and DATA and 0 in IDLE.
REQ-024 mem_ack in FETCH or DATA SHALL return the FSM to IDLE and capture mem_rdata into the granted requester's rdata register (DATA read only; a store SHALL leave m_rdata unchanged).
REQ-025 The done pulse SHALL be registered: asserted the cycle after mem_ack, for exactly one cycle.
REQ-026 Minimum transaction = 3 cycles from request to done (grant edge, ack cycle with zero-wait memory, done cycle); back-to-back grants SHALL have one IDLE cycle between them.
REQ-027 m_stall = (m_MemRead|m_MemWrite) && !m_done, combinational.
REQ-028 if_stall = if_req && !if_done && !if_flush, combinational.
REQ-029 Starvation counter (4 bits): +1 on each DATA grant while if_req=1; cleared on each FETCH grant or while if_req=0; saturates at STARVE_LIMIT.
REQ-030 if_flush while FETCH: the transaction SHALL complete on the memory side, but if_done SHALL NOT pulse and if_rdata SHALL NOT update.
REQ-031 if_flush in IDLE SHALL suppress a FETCH grant in that cycle.
REQ-032 The abort record from REQ-030 SHALL be cleared on return to IDLE.
REQ-033 mem_ack in IDLE SHALL be ignored.
REQ-034 Request changes while FETCH or DATA SHALL have no effect until IDLE.

Reset
REQ-035 rst_n=0 SHALL immediately force: state IDLE; mem_req, mem_we, if_done and m_done 0; mem_addr, mem_wdata, if_rdata and m_rdata 0; starvation counter 0; abort record clear.
REQ-036 Reset mid-transaction SHALL drop mem_req asynchronously; a later mem_ack SHALL be ignored per REQ-033.
REQ-037 The first grant after reset SHALL be evaluated on the first rising edge with rst_n=1.

Verification
REQ-038 Single load: m_MemRead=1, m_alu_out=0x1003, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x1000, mem_we=0, m_done pulses once, m_rdata=0xDEADBEEF, m_stall=0 in the done cycle.
REQ-039 Store: m_MemWrite=1, m_alu_out=0x20, m_mem_data=0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 held until ack; m_rdata unchanged.
REQ-040 Simultaneous: if_req and m_MemRead both asserted in IDLE -> DATA granted first, FETCH granted after one IDLE cycle; if_stall=1 throughout.
REQ-041 Starvation: STARVE_LIMIT=2, if_req held with data requests every cycle -> after two DATA grants the third grant is FETCH, then the counter reads 0.
REQ-042 Flush: if_flush pulsed during FETCH with mem_ack delayed 3 cycles -> mem_req held to ack, no if_done, if_rdata unchanged.
REQ-043 Reset during DATA with mem_ack pending -> mem_req=0 immediately; an ack after release produces no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one shared word memory port between instruction fetch and the data stage.
// Latency: the grant is taken on the first edge, ack in the next cycle at the earliest, then a registered done pulse (3 cycles minimum).
// Backpressure: the requesters are held by if_stall/m_stall until done; a slow mem_ack keeps mem_req and its payload asserted.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        m_stall,
    output logic        if_done,
    output logic        m_done,
    output logic [31:0] if_rdata,
    output logic [31:0] m_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_if_done;
    logic        r_m_done;
    logic [31:0] r_if_rdata;
    logic [31:0] r_m_rdata;
    logic [3:0]  r_starve_cnt;
    logic        r_abort;

    logic        w_data_req;
    logic        w_fetch_ok;
    logic        w_starved;
    logic        w_grant_data;
    logic        w_grant_fetch;
    logic        w_fetch_ack;
    logic        w_data_ack;
    logic        w_unused;

    // The address byte-lane bits never reach the word-wide memory.
    assign w_unused = ^{if_addr[1:0], m_alu_out[1:0]};

    // Grant decision in IDLE: data wins unless the fetch has waited STARVE_LIMIT data grants.
    always_comb begin
        w_data_req    = m_MemRead | m_MemWrite;
        w_fetch_ok    = if_req & ~if_flush;
        w_starved     = (r_starve_cnt == LIMIT) & w_fetch_ok;
        w_grant_data  = (r_state == S_IDLE) & w_data_req & ~w_starved;
        w_grant_fetch = (r_state == S_IDLE) & w_fetch_ok & ~w_grant_data;
        w_fetch_ack   = (r_state == S_FETCH) & mem_ack;
        w_data_ack    = (r_state == S_DATA) & mem_ack;
    end

    // State register plus the transaction payload captured on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            if (w_grant_data) begin
                r_state     <= S_DATA;
                r_mem_we    <= m_MemWrite;
                r_mem_addr  <= {m_alu_out[31:2], 2'b00};
                r_mem_wdata <= m_mem_data;
            end else if (w_grant_fetch) begin
                r_state     <= S_FETCH;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {if_addr[31:2], 2'b00};
                r_mem_wdata <= 32'h0;
            end else if (w_fetch_ack || w_data_ack) begin
                r_state     <= S_IDLE;
            end
        end
    end

    // A flush seen at any point of a fetch turns its completion into a silent drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort <= 1'b0;
        end else if (r_state != S_FETCH || mem_ack) begin
            r_abort <= 1'b0;
        end else if (if_flush) begin
            r_abort <= 1'b1;
        end
    end

    // Completion: one-cycle done pulses and per-requester read data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_done  <= 1'b0;
            r_m_done   <= 1'b0;
            r_if_rdata <= 32'h0;
            r_m_rdata  <= 32'h0;
        end else begin
            r_if_done <= w_fetch_ack & ~r_abort & ~if_flush;
            r_m_done  <= w_data_ack;
            if (w_fetch_ack && !r_abort && !if_flush) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_data_ack && !r_mem_we) begin
                r_m_rdata <= mem_rdata;
            end
        end
    end

    // Count data grants taken while a fetch waits; any fetch grant or idle fetch side resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!if_req || w_grant_fetch) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_data && r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Outputs: mem_req follows the state register so reset drops it at once.
    always_comb begin
        mem_req   = (r_state != S_IDLE);
        mem_we    = r_mem_we;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        if_done   = r_if_done;
        m_done    = r_m_done;
        if_rdata  = r_if_rdata;
        m_rdata   = r_m_rdata;
        m_stall   = (m_MemRead | m_MemWrite) & ~r_m_done;
        if_stall  = if_req & ~r_if_done & ~if_flush;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed and randomized checks of mem_arbiter against a transaction-level reference model.
// Latency: every cycle is compared 1 time unit after the rising edge.
// Backpressure: the bench plays both requesters and a memory with random ack delay.
module tb_mem_arbiter;

    localparam int SL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_flush = 1'b0;
    logic        m_MemRead = 1'b0;
    logic        m_MemWrite = 1'b0;
    logic [31:0] m_alu_out = 32'h0;
    logic [31:0] m_mem_data = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        if_stall;
    logic        m_stall;
    logic        if_done;
    logic        m_done;
    logic [31:0] if_rdata;
    logic [31:0] m_rdata;

    mem_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite),
        .m_alu_out(m_alu_out), .m_mem_data(m_mem_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .m_stall(m_stall),
        .if_done(if_done), .m_done(m_done),
        .if_rdata(if_rdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the memory, the open transaction, and per-requester results.
    int          owner;       // 0 = nobody, 1 = fetch, 2 = data
    int          data_streak; // data grants taken while the fetch kept waiting
    bit          fetch_cancelled;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_m_rdata;
    logic        e_if_done, e_m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; data_streak = 0; fetch_cancelled = 0;
        e_we = 0; e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_m_rdata = 0;
        e_if_done = 0; e_m_done = 0;
    endtask

    // Advance the model across one rising edge using the inputs presented before it.
    task automatic model_edge();
        bit wants_data, wants_fetch;
        e_if_done = 0;
        e_m_done  = 0;
        if (owner == 0) begin
            wants_data  = m_MemRead || m_MemWrite;
            wants_fetch = if_req && !if_flush;
            if (wants_data && !(wants_fetch && data_streak == SL)) begin
                owner = 2; e_we = m_MemWrite;
                e_addr = m_alu_out & 32'hFFFF_FFFC; e_wdata = m_mem_data;
                if (if_req && data_streak < SL) data_streak++;
            end else if (wants_fetch) begin
                owner = 1; e_we = 0;
                e_addr = if_addr & 32'hFFFF_FFFC; e_wdata = 0;
                data_streak = 0;
            end
        end else if (owner == 1) begin
            if (if_flush) fetch_cancelled = 1;
            if (mem_ack) begin
                if (!fetch_cancelled) begin e_if_done = 1; e_if_rdata = mem_rdata; end
                owner = 0; fetch_cancelled = 0;
            end
        end else begin
            if (mem_ack) begin
                e_m_done = 1;
                if (!e_we) e_m_rdata = mem_rdata;
                owner = 0;
            end
        end
        if (!if_req) data_streak = 0;
    endtask

    task automatic compare_all();
        chk("mem_req", mem_req, owner != 0);
        if (owner != 0) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
        chk("if_done", if_done, e_if_done);
        chk("m_done", m_done, e_m_done);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("m_rdata", m_rdata, e_m_rdata);
        chk("m_stall", m_stall, (m_MemRead || m_MemWrite) && !e_m_done);
        chk("if_stall", if_stall, if_req && !e_if_done && !if_flush);
    endtask

    task automatic tick();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        bit prev_flush;

        // Reset values
        model_reset();
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_dones", {if_done, m_done}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_m_rdata", m_rdata, 0);
        @(negedge clk);
        rst_n = 1;

        // Single load with zero-wait memory
        m_MemRead = 1; m_alu_out = 32'h1003;
        tick();
        chk("ld_addr", mem_addr, 32'h1000);
        chk("ld_we", mem_we, 0);
        chk("ld_stall", m_stall, 1);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("ld_done", m_done, 1);
        chk("ld_rdata", m_rdata, 32'hDEADBEEF);
        chk("ld_stall_done", m_stall, 0);
        m_MemRead = 0; mem_ack = 0;
        tick();
        chk("ld_done_once", m_done, 0);

        // Store held for an extra cycle; m_rdata untouched
        m_MemWrite = 1; m_alu_out = 32'h20; m_mem_data = 32'h12345678;
        tick();
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 32'h20);
        chk("st_wdata", mem_wdata, 32'h12345678);
        m_alu_out = 32'h444; m_mem_data = 32'hFFFF0000;
        tick();
        chk("st_addr_hold", mem_addr, 32'h20);
        chk("st_wdata_hold", mem_wdata, 32'h12345678);
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        tick();
        chk("st_done", m_done, 1);
        chk("st_rdata_kept", m_rdata, 32'hDEADBEEF);
        m_MemWrite = 0; mem_ack = 0;
        tick();

        // Simultaneous requests: data first, fetch after one idle cycle
        if_req = 1; if_addr = 32'h400; m_MemRead = 1; m_alu_out = 32'h80;
        tick();
        chk("sim_first_data", mem_addr, 32'h80);
        chk("sim_if_stall1", if_stall, 1);
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        chk("sim_idle_gap", mem_req, 0);
        chk("sim_if_stall2", if_stall, 1);
        m_MemRead = 0; mem_ack = 0;
        tick();
        chk("sim_then_fetch", mem_addr, 32'h400);
        chk("sim_if_stall3", if_stall, 1);
        mem_ack = 1; mem_rdata = 32'h22222222;
        tick();
        chk("sim_if_done", if_done, 1);
        chk("sim_if_rdata", if_rdata, 32'h22222222);
        if_req = 0; mem_ack = 0;
        tick();

        // Starvation: two data grants, then the fetch is forced
        if_req = 1; if_addr = 32'h400; m_MemRead = 1; m_alu_out = 32'h80;
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("starve_data_grant", mem_addr, 32'h80);
            mem_ack = 1; mem_rdata = 32'h55555555;
            tick();
            mem_ack = 0;
        end
        tick();
        chk("starve_fetch_grant", mem_addr, 32'h400);
        chk("starve_cnt_cleared", 32'(dut.r_starve_cnt), 0);
        mem_ack = 1; mem_rdata = 32'h44444444;
        tick();
        chk("starve_if_done", if_done, 1);
        if_req = 0; m_MemRead = 0; mem_ack = 0;
        tick();

        // Flush during a fetch with a slow memory
        if_req = 1; if_addr = 32'h500; mem_rdata = 32'h33333333;
        tick();
        chk("fl_fetch_addr", mem_addr, 32'h500);
        if_flush = 1;
        tick();
        chk("fl_req_held1", mem_req, 1);
        if_flush = 0; if_req = 0;
        tick();
        chk("fl_req_held2", mem_req, 1);
        tick();
        chk("fl_req_held3", mem_req, 1);
        mem_ack = 1;
        tick();
        chk("fl_no_done", if_done, 0);
        chk("fl_rdata_kept", if_rdata, 32'h44444444);
        mem_ack = 0;
        tick();

        // Reset in the middle of a load, then a stray ack
        m_MemRead = 1; m_alu_out = 32'h60;
        tick();
        chk("rd_granted", mem_req, 1);
        #2 rst_n = 0;
        #1 chk("rd_req_dropped", mem_req, 0);
        model_reset();
        m_MemRead = 0;
        @(negedge clk);
        rst_n = 1; mem_ack = 1; mem_rdata = 32'h66666666;
        tick();
        chk("rd_no_done", m_done, 0);
        mem_ack = 0;
        tick();
        chk("rd_still_no_done", m_done, 0);

        // Randomized traffic against the model
        prev_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            if (if_done || prev_flush) if_req = 0;
            if (m_done) begin m_MemRead = 0; m_MemWrite = 0; end
            prev_flush = 0; if_flush = 0;
            if (!if_req) begin
                if ($urandom_range(3) == 0) begin if_req = 1; if_addr = $urandom; end
            end else if ($urandom_range(15) == 0) begin
                if_flush = 1; prev_flush = 1;
            end
            if (!(m_MemRead || m_MemWrite) && $urandom_range(2) == 0) begin
                if ($urandom_range(1) == 1) m_MemRead = 1; else m_MemWrite = 1;
                m_alu_out = $urandom; m_mem_data = $urandom;
            end
            mem_ack = mem_req ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
            mem_rdata = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
